// File: rtl/spi_pkg.sv
// Shared definitions for the 16-bit SPI register-write link: frame layout, FSM states
// and the register map the peripheral decodes.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] REG_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] REG_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] REG_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] REG_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] REG_DUTY     = 7'h04;

  function automatic logic [FRAME_W-1:0] pack_frame(input logic w,
                                                    input logic [ADDR_W-1:0] addr,
                                                    input logic [DATA_W-1:0] data);
    return {w, addr, data};
  endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI serial clock: strobes one cycle before sclk is due to toggle,
// tagged as rise or fall from the current sclk level.
module spi_clk_gen #(
  parameter int HALF_PERIOD = 8,
  localparam int CNT_W = $clog2(HALF_PERIOD)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic sclk_i,
  output logic rise_o,
  output logic fall_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc;

  assign tc = en_i && (cnt_q == CNT_W'(HALF_PERIOD - 1));

  // Counter rests at zero while disabled so every frame starts on a full half-period.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || tc) cnt_d = '0;
    else             cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign rise_o = tc & ~sclk_i;
  assign fall_o = tc &  sclk_i;

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 write controller: latches one {write, addr, data} frame and shifts it out MSB-first.
// Handshake: a request transfers in any cycle where req_valid_i and req_ready_o are both high.
module spi_controller
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 8,
  parameter int CS_GAP      = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              sclk_o,
  output logic              ncs_o,
  output logic              copi_o,
  output logic              busy_o,
  output logic              done_o,
  output state_e            state_o
);

  localparam int GAP_W = $clog2(CS_GAP + 1);

  state_e               state_q, state_d;
  logic [FRAME_W-2:0]   shreg_q, shreg_d;
  logic [3:0]           bit_q, bit_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 sclk_q, sclk_d;
  logic                 ncs_q, ncs_d;
  logic                 copi_q, copi_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [FRAME_W-1:0]   frame_w;
  logic                 hp_en, hp_rise, hp_fall;

  assign frame_w = pack_frame(req_write_i, req_addr_i, req_data_i);
  assign hp_en   = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);

  spi_clk_gen #(.HALF_PERIOD(HALF_PERIOD)) u_clk_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (hp_en),
    .sclk_i (sclk_q),
    .rise_o (hp_rise),
    .fall_o (hp_fall)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sclk_d  = sclk_q;
    ncs_d   = ncs_q;
    copi_d  = copi_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d = ST_SETUP;
          copi_d  = frame_w[FRAME_W-1];
          shreg_d = frame_w[FRAME_W-2:0];
          bit_d   = 4'd0;
          ncs_d   = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (hp_rise) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (hp_rise) begin
          sclk_d = 1'b1;
        end else if (hp_fall) begin
          // Data moves only on the falling edge, so it is stable across the whole high phase.
          sclk_d = 1'b0;
          if (bit_q == 4'd15) begin
            state_d = ST_HOLD;
            copi_d  = 1'b0;
          end else begin
            bit_d   = bit_q + 4'd1;
            copi_d  = shreg_q[FRAME_W-2];
            shreg_d = {shreg_q[FRAME_W-3:0], 1'b0};
          end
        end
      end
      ST_HOLD: begin
        if (hp_rise) begin
          state_d = ST_GAP;
          ncs_d   = 1'b1;
          gap_d   = '0;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_W'(CS_GAP - 1)) begin
          state_d = ST_IDLE;
          gap_d   = '0;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      ncs_q   <= ncs_d;
      copi_q  <= copi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign req_ready_o = ready_q;
  assign sclk_o      = sclk_q;
  assign ncs_o       = ncs_q;
  assign copi_o      = copi_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: a pin-level SPI receiver model with the peripheral's register map,
// a default-timing instance for frame/handshake tests and a HALF_PERIOD=4 instance for timing.
module tb_spi_controller;
  import spi_pkg::*;

  localparam int H  = 8;
  localparam int G  = 4;
  localparam int H4 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (default timing) ----------------
  logic       req_valid, req_write, req_ready, sclk, ncs, copi, busy, done;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  state_e     state;

  spi_controller #(.HALF_PERIOD(H), .CS_GAP(G)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_write_i(req_write), .req_addr_i(req_addr), .req_data_i(req_data),
    .sclk_o(sclk), .ncs_o(ncs), .copi_o(copi), .busy_o(busy), .done_o(done), .state_o(state)
  );

  // ---------------- DUT (fast timing) ----------------
  logic       v4, w4, ready4, sclk4, ncs4, copi4, busy4, done4;
  logic [6:0] a4;
  logic [7:0] d4;
  state_e     state4;

  spi_controller #(.HALF_PERIOD(H4), .CS_GAP(G)) dut4 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(v4), .req_ready_o(ready4),
    .req_write_i(w4), .req_addr_i(a4), .req_data_i(d4),
    .sclk_o(sclk4), .ncs_o(ncs4), .copi_o(copi4), .busy_o(busy4), .done_o(done4), .state_o(state4)
  );

  // ---------------- receiver model (default DUT) ----------------
  logic        p_sclk = 1'b0, p_ncs = 1'b1, p_copi = 1'b0;
  logic [15:0] rx_sh = '0, last_frame = '0;
  int          rx_bits = 0, rises = 0, last_bits = 0, last_rises = 0, frame_cnt = 0;
  int          ncs_fall_cyc = 0, ncs_rise_cyc = 0, last_low_len = 0, last_gap_len = 0;
  int          copi_viol = 0, stray_rises = 0, idx;
  logic [7:0]  regs [5] = '{default: 8'h00};

  always @(negedge clk) begin
    if (!p_ncs && ncs) begin
      last_frame   = rx_sh;
      last_bits    = rx_bits;
      last_rises   = rises;
      last_low_len = cyc - ncs_fall_cyc;
      ncs_rise_cyc = cyc;
      frame_cnt++;
      idx = int'(rx_sh[14:8]);
      if (rx_bits == 16 && rx_sh[15] && idx <= 4) regs[idx] = rx_sh[7:0];
    end
    if (p_ncs && !ncs) begin
      ncs_fall_cyc = cyc;
      last_gap_len = cyc - ncs_rise_cyc;
      rx_bits = 0; rises = 0; rx_sh = '0;
    end
    if (!p_sclk && sclk) begin
      if (!ncs) begin rx_sh = {rx_sh[14:0], copi}; rx_bits++; rises++; end
      else stray_rises++;
    end
    if (p_sclk && sclk && copi !== p_copi) copi_viol++;
    p_sclk = sclk; p_ncs = ncs; p_copi = copi;
  end

  // ---------------- phase monitor (fast DUT) ----------------
  logic        p4_sclk = 1'b0, p4_ncs = 1'b1, p4_copi = 1'b0, seen_fall4 = 1'b0;
  logic [15:0] rx4 = '0;
  int          last_edge4 = 0, ncs_fall4 = 0, rises4 = 0, viol4 = 0, setup4 = 0, hold4 = 0;
  int          hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;

  always @(negedge clk) begin
    if (p4_ncs && !ncs4) begin ncs_fall4 = cyc; seen_fall4 = 1'b0; end
    if (!p4_ncs && ncs4) hold4 = cyc - last_edge4;
    if (!p4_sclk && sclk4 && !ncs4) begin
      if (rises4 == 0) setup4 = cyc - ncs_fall4;
      if (seen_fall4) begin
        if (cyc - last_edge4 < lo_min) lo_min = cyc - last_edge4;
        if (cyc - last_edge4 > lo_max) lo_max = cyc - last_edge4;
      end
      rx4 = {rx4[14:0], copi4};
      rises4++;
      last_edge4 = cyc;
    end
    if (p4_sclk && !sclk4) begin
      if (cyc - last_edge4 < hi_min) hi_min = cyc - last_edge4;
      if (cyc - last_edge4 > hi_max) hi_max = cyc - last_edge4;
      last_edge4 = cyc;
      seen_fall4 = 1'b1;
    end
    if (p4_sclk && sclk4 && copi4 !== p4_copi) viol4++;
    p4_sclk = sclk4; p4_ncs = ncs4; p4_copi = copi4;
  end

  // ---------------- scoreboard helpers ----------------
  int tests = 0, fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic w, input logic [6:0] a, input logic [7:0] d, output int t_acc);
    req_write = w; req_addr = a; req_data = d; req_valid = 1'b1;
    t_acc = -1;
    for (int i = 0; i < 1000; i++) begin
      if (req_ready) begin t_acc = cyc; break; end
      step();
    end
    step();
    req_valid = 1'b0;
    check("accept_timeout", 32'(t_acc >= 0), 32'd1);
  endtask

  task automatic wait_done(output int t_done);
    t_done = -1;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (done) begin t_done = cyc; break; end
    end
    check("done_timeout", 32'(t_done >= 0), 32'd1);
  endtask

  task automatic wait_bits(input int n);
    int ok = 0;
    for (int i = 0; i < 1000; i++) begin
      if (rx_bits >= n) begin ok = 1; break; end
      step();
    end
    check("bit_wait_timeout", 32'(ok), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ncs"},   32'(ncs),       32'd1);
    check({tag, "_sclk"},  32'(sclk),      32'd0);
    check({tag, "_copi"},  32'(copi),      32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_busy"},  32'(busy),      32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_state"}, 32'(state),     32'(ST_IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        w;
    logic [6:0]  addr;
    logic [7:0]  data;
    logic [15:0] exp_frame;
    bit          upd;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] exp_regs [5] = '{default: 8'h00};

  initial begin
    int t_acc, t_done, t1, td1, td2, fc0;
    vecs[0] = '{1'b1, 7'h04, 8'hA5, 16'h84A5, 1'b1};
    vecs[1] = '{1'b1, 7'h00, 8'h3C, 16'h803C, 1'b1};
    vecs[2] = '{1'b1, 7'h01, 8'h5A, 16'h815A, 1'b1};
    vecs[3] = '{1'b1, 7'h02, 8'h96, 16'h8296, 1'b1};
    vecs[4] = '{1'b1, 7'h03, 8'h0F, 16'h830F, 1'b1};
    vecs[5] = '{1'b0, 7'h02, 8'hFF, 16'h02FF, 1'b0};
    vecs[6] = '{1'b1, 7'h7F, 8'h11, 16'hFF11, 1'b0};

    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
    v4 = 1'b0; w4 = 1'b0; a4 = '0; d4 = '0;
    rst_n = 1'b0;
    repeat (3) step();
    check_idle("reset");
    rst_n = 1'b1;
    step();

    // Single writes, including a read-flagged frame and an undefined address.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].w, vecs[i].addr, vecs[i].data, t_acc);
      wait_done(t_done);
      if (vecs[i].upd) exp_regs[int'(vecs[i].addr)] = vecs[i].data;
      check($sformatf("v%0d_frame", i),   32'(last_frame),    32'(vecs[i].exp_frame));
      check($sformatf("v%0d_rises", i),   32'(last_rises),    32'd16);
      check($sformatf("v%0d_ncs_low", i), 32'(last_low_len),  32'(33 * H));
      check($sformatf("v%0d_latency", i), 32'(t_done - t_acc), 32'(33 * H + 1 + G));
      check($sformatf("v%0d_ready", i),   32'(req_ready),     32'd1);
      for (int r = 0; r < 5; r++)
        check($sformatf("v%0d_reg%0d", i, r), 32'(regs[r]), 32'(exp_regs[r]));
    end
    check("copi_while_high", 32'(copi_viol),   32'd0);
    check("stray_sclk",      32'(stray_rises), 32'd0);

    // Back-to-back: valid held, second request accepted in the done cycle.
    fc0 = frame_cnt;
    req_write = 1'b1; req_addr = 7'h00; req_data = 8'hFF; req_valid = 1'b1;
    t1 = -1;
    for (int i = 0; i < 1000; i++) begin
      if (req_ready) begin t1 = cyc; break; end
      step();
    end
    check("b2b_accept_timeout", 32'(t1 >= 0), 32'd1);
    step();
    req_addr = 7'h01; req_data = 8'h0F;
    wait_done(td1);
    check("b2b_f1_latency", 32'(td1 - t1),    32'(33 * H + 1 + G));
    check("b2b_f1_frame",   32'(last_frame),  32'h80FF);
    check("b2b_f1_valid_ready_coincide", 32'(req_ready & req_valid), 32'd1);
    step();
    req_valid = 1'b0;
    check("b2b_f2_ncs_low_next", 32'(ncs), 32'd0);
    wait_done(td2);
    exp_regs[0] = 8'hFF; exp_regs[1] = 8'h0F;
    check("b2b_f2_latency", 32'(td2 - td1),  32'(33 * H + 1 + G));
    check("b2b_f2_frame",   32'(last_frame), 32'h810F);
    // ncs stays high through the GAP cycles plus the done/accept cycle.
    check("b2b_gap",        32'(last_gap_len), 32'(G + 1));
    check("b2b_reg0",       32'(regs[0]), 32'h0FF);
    check("b2b_reg1",       32'(regs[1]), 32'h00F);
    repeat (20) step();
    check("b2b_frame_count", 32'(frame_cnt - fc0), 32'd2);

    // Request pulsed mid-frame must be ignored.
    fc0 = frame_cnt;
    send(1'b1, 7'h02, 8'h33, t_acc);
    wait_bits(3);
    req_write = 1'b1; req_addr = 7'h03; req_data = 8'h77; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    wait_done(t_done);
    exp_regs[2] = 8'h33;
    check("ign_frame",   32'(last_frame), 32'h8233);
    check("ign_reg2",    32'(regs[2]),    32'(exp_regs[2]));
    check("ign_reg3",    32'(regs[3]),    32'(exp_regs[3]));
    repeat (40) step();
    check("ign_frame_count", 32'(frame_cnt - fc0), 32'd1);
    check("ign_ncs_idle",    32'(ncs),             32'd1);

    // Reset held three cycles during bit 5.
    fc0 = frame_cnt;
    send(1'b1, 7'h01, 8'hEE, t_acc);
    wait_bits(5);
    rst_n = 1'b0;
    step();
    check_idle("midrst");
    step(); step();
    rst_n = 1'b1;
    step();
    check("midrst_partial_bits", 32'(last_bits), 32'd5);
    check("midrst_frame_count",  32'(frame_cnt - fc0), 32'd1);
    check("midrst_reg1_kept",    32'(regs[1]), 32'(exp_regs[1]));

    // HALF_PERIOD=4 timing.
    w4 = 1'b1; a4 = 7'h03; d4 = 8'hC3; v4 = 1'b1;
    t1 = -1;
    for (int i = 0; i < 100; i++) begin
      if (ready4) begin t1 = cyc; break; end
      step();
    end
    check("hp4_accept_timeout", 32'(t1 >= 0), 32'd1);
    step();
    v4 = 1'b0;
    td1 = -1;
    for (int i = 0; i < 500; i++) begin
      step();
      if (done4) begin td1 = cyc; break; end
    end
    check("hp4_done_timeout", 32'(td1 >= 0), 32'd1);
    check("hp4_latency", 32'(td1 - t1), 32'(33 * H4 + 1 + G));
    check("hp4_frame",   32'(rx4),      32'h83C3);
    check("hp4_rises",   32'(rises4),   32'd16);
    check("hp4_hi_min",  32'(hi_min),   32'(H4));
    check("hp4_hi_max",  32'(hi_max),   32'(H4));
    check("hp4_lo_min",  32'(lo_min),   32'(H4));
    check("hp4_lo_max",  32'(lo_max),   32'(H4));
    check("hp4_setup",   32'(setup4),   32'(H4));
    check("hp4_hold",    32'(hold4),    32'(H4));
    check("hp4_copi_while_high", 32'(viol4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
